// File: rtl/icache_responder_pkg.sv
// Shared types and width helpers for the instruction-cache responder.
package icache_responder_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFill
    } state_e;

    // Word-offset width for a given line size in words.
    function automatic int unsigned calc_off_w(input int unsigned words);
        return $clog2(words);
    endfunction

    // Line-index width for a given number of lines.
    function automatic int unsigned calc_idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag width: everything above index, offset and the byte-in-word bits.
    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned lines,
                                               input int unsigned words);
        return addr_w - $clog2(lines) - $clog2(words) - 2;
    endfunction

    // Widths for the default configuration (16 lines x 4 words, 32-bit address).
    localparam int unsigned OFF_W = calc_off_w(4);
    localparam int unsigned IDX_W = calc_idx_w(16);
    localparam int unsigned TAG_W = calc_tag_w(32, 16, 4);

endpackage

// File: rtl/icache_data_array.sv
// Instruction data store: LINES x WORDS 32-bit words, one word written per
// cycle during refill, asynchronous read for zero-latency hits.
module icache_data_array #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(LINES)-1:0]   widx_i,
    input  logic [$clog2(WORDS)-1:0]   woff_i,
    input  logic [31:0]                wdata_i,
    input  logic [$clog2(LINES)-1:0]   ridx_i,
    input  logic [$clog2(WORDS)-1:0]   roff_i,
    output logic [31:0]                rdata_o
);

    logic [31:0] mem_q [LINES*WORDS];

    // Refill write port; contents need no reset because valid bits gate use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{widx_i, woff_i}] <= wdata_i;
        end
    end

    // Asynchronous read of the addressed word.
    always_comb begin
        rdata_o = mem_q[{ridx_i, roff_i}];
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder: combinational hits, stall on
// miss, and a whole-line refill over a request handshake plus data beats.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int unsigned LINES  = 16,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              stall,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned OffW    = calc_off_w(WORDS);
    localparam int unsigned IdxW    = calc_idx_w(LINES);
    localparam int unsigned TagW    = calc_tag_w(ADDR_W, LINES, WORDS);
    localparam int unsigned LineLsb = OffW + 2;
    localparam logic [ADDR_W-1:0] LineMask = {{(ADDR_W - LineLsb){1'b1}}, {LineLsb{1'b0}}};
    localparam logic [OffW-1:0] LastBeat = OffW'(WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [OffW-1:0]     cnt_q, cnt_d;
    logic                flushed_q, flushed_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TagW-1:0]     tag_q [LINES];
    logic                tag_we;

    logic [OffW-1:0]     req_off;
    logic [IdxW-1:0]     req_idx;
    logic [TagW-1:0]     req_tag;
    logic [IdxW-1:0]     fill_idx;
    logic [TagW-1:0]     fill_tag;
    logic [31:0]         rd_word;
    logic                hit;
    logic                beat;
    logic                data_we;

    // Split the fetch PC and the captured refill address into fields.
    always_comb begin
        req_off  = req_addr[OffW+1:2];
        req_idx  = req_addr[LineLsb +: IdxW];
        req_tag  = req_addr[ADDR_W-1 -: TagW];
        fill_idx = line_addr_q[LineLsb +: IdxW];
        fill_tag = line_addr_q[ADDR_W-1 -: TagW];
    end

    // Hit detection and refill beat qualification.
    always_comb begin
        hit     = (state_q == StIdle) && req_valid && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);
        beat    = (state_q == StFill) && mem_rvalid;
        data_we = beat;
    end

    icache_data_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_data (
        .clk_i   (clk),
        .we_i    (data_we),
        .widx_i  (fill_idx),
        .woff_i  (cnt_q),
        .wdata_i (mem_rdata),
        .ridx_i  (req_idx),
        .roff_i  (req_off),
        .rdata_o (rd_word)
    );

    // Next-state logic and outputs of the refill controller.
    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        cnt_d         = cnt_q;
        flushed_d     = flushed_q;
        valid_d       = valid_q;
        tag_we        = 1'b0;
        instr         = 32'h0000_0000;
        stall         = 1'b0;
        mem_req_valid = 1'b0;

        if (flush) begin
            valid_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                flushed_d = 1'b0;
                if (req_valid) begin
                    if (hit) begin
                        instr = rd_word;
                    end else begin
                        stall       = 1'b1;
                        line_addr_d = req_addr & LineMask;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                stall = 1'b1;
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (beat) begin
                    cnt_d = cnt_q + OffW'(1);
                    if (cnt_q == LastBeat) begin
                        // A flush seen at any point of the refill leaves the line invalid.
                        tag_we            = 1'b1;
                        valid_d[fill_idx] = ~(flushed_q | flush);
                        cnt_d             = '0;
                        flushed_d         = 1'b0;
                        state_d           = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller state, captured line address, beat counter and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
            valid_q     <= valid_d;
        end
    end

    // Tag array, written once per completed refill.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    assign mem_req_addr = line_addr_q;

endmodule
